fetch_unit: RTL and testbench

Instruction fetch stage for the nibble processor: holds the 12-bit program counter, drives the address of the 4Kx8 program ROM, captures the returned byte into an instruction register split into `instr` (high nibble) and `oprnd` (low nibble), and offers it to the decoder with a valid/ready handshake. Sits directly upstream of the ROM (address) and directly downstream of it (data).

---
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage for the nibble processor. Holds the
//               program counter, addresses the program ROM, captures the
//               returned byte into an instruction register split into an
//               opcode nibble and an operand nibble, and offers it to the
//               decoder through a valid/ready handshake.
//               Optional feature macro: FETCH_HALT_ON_WRAP_EN
//               (defined: fetch stops in HALT after the word at the last
//               address is consumed; undefined: fetch wraps and continues).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   load_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [ADDR_W-1:0]   pc,
    output logic [DATA_W/2-1:0] instr,
    output logic [DATA_W/2-1:0] oprnd,
    output logic                valid,
    input  logic                ready,
    output logic                halted
);

    localparam int               HALF_W    = DATA_W / 2;
    localparam logic [ADDR_W-1:0] C_PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_PC_LAST = {ADDR_W{1'b1}};

`ifdef FETCH_HALT_ON_WRAP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [HALF_W-1:0]  r_instr;
    logic [HALF_W-1:0]  r_oprnd;
    logic               w_capture;

`ifdef FETCH_HALT_ON_WRAP_EN
    // Marks that the word currently held came from the last ROM address,
    // so its acceptance must park the FSM in HALT.
    logic               r_wrap;
    logic               w_wrap_set;
    logic               w_wrap_clr;
`endif

    // State register: IDLE after reset, otherwise follows next-state logic.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter: cleared by reset, loaded or incremented per next-state logic.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Instruction register: captures the ROM word only on an uncancelled FETCH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_instr <= '0;
            r_oprnd <= '0;
        end else if (w_capture) begin
            r_instr <= rom_data[DATA_W-1:HALF_W];
            r_oprnd <= rom_data[HALF_W-1:0];
        end
    end

`ifdef FETCH_HALT_ON_WRAP_EN
    // Wrap marker: set when the last address is fetched, cleared on leaving it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_clr) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_set) begin
            r_wrap <= 1'b1;
        end
    end
`endif

    // Next-state, PC update and capture control; pc_load overrides everything,
    // including a handshake happening in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_capture    = 1'b0;
`ifdef FETCH_HALT_ON_WRAP_EN
        w_wrap_set   = 1'b0;
        w_wrap_clr   = 1'b0;
`endif
        if (pc_load) begin
            w_state_next = S_IDLE;
            w_pc_next    = load_addr;
`ifdef FETCH_HALT_ON_WRAP_EN
            w_wrap_clr   = 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ROM read is combinational, so the word is captured on
                    // the single edge that closes FETCH.
                    w_capture    = 1'b1;
                    w_pc_next    = r_pc + C_PC_ONE;
                    w_state_next = S_HOLD;
`ifdef FETCH_HALT_ON_WRAP_EN
                    w_wrap_set   = (r_pc == C_PC_LAST);
`endif
                end
                S_HOLD: begin
                    if (ready) begin
`ifdef FETCH_HALT_ON_WRAP_EN
                        if (r_wrap) begin
                            w_state_next = S_HALT;
                            w_wrap_clr   = 1'b1;
                        end else if (run) begin
                            w_state_next = S_FETCH;
                        end else begin
                            w_state_next = S_IDLE;
                        end
`else
                        if (run) begin
                            w_state_next = S_FETCH;
                        end else begin
                            w_state_next = S_IDLE;
                        end
`endif
                    end
                end
`ifdef FETCH_HALT_ON_WRAP_EN
                S_HALT: begin
                    // Only pc_load or reset leave HALT.
                    w_state_next = S_HALT;
                end
`endif
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = r_pc;
    assign pc       = r_pc;
    assign instr    = r_instr;
    assign oprnd    = r_oprnd;
    assign valid    = (r_state == S_HOLD);

`ifdef FETCH_HALT_ON_WRAP_EN
    assign halted   = (r_state == S_HALT);
`else
    assign halted   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a behavioural
//               4Kx8 ROM and hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        pc_load;
    logic [11:0] load_addr;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [11:0] pc;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        valid;
    logic        ready;
    logic        halted;

    logic [7:0]  rom [0:4095];

    int cmp_cnt;
    int fail_cnt;

    fetch_unit #(
        .ADDR_W (12),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .pc_load   (pc_load),
        .load_addr (load_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pc        (pc),
        .instr     (instr),
        .oprnd     (oprnd),
        .valid     (valid),
        .ready     (ready),
        .halted    (halted)
    );

    // Combinational ROM read.
    assign rom_data = rom[rom_addr];

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full observable fetch state in one call.
    task automatic chk_all(input string tag, input logic v, input logic [3:0] ei,
                           input logic [3:0] eo, input logic [11:0] ep);
        chk({tag, ".valid"}, {15'd0, valid}, {15'd0, v});
        chk({tag, ".instr"}, {12'd0, instr}, {12'd0, ei});
        chk({tag, ".oprnd"}, {12'd0, oprnd}, {12'd0, eo});
        chk({tag, ".pc"},    {4'd0, pc},     {4'd0, ep});
    endtask

    initial begin
        cmp_cnt  = 0;
        fail_cnt = 0;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 8'((i * 37) + 11);
        end
        rom[12'h000] = 8'h12;
        rom[12'h001] = 8'h34;
        rom[12'h002] = 8'h56;
        rom[12'h003] = 8'h78;
        rom[12'h004] = 8'h9A;
        rom[12'h0A5] = 8'hC3;
        rom[12'hFFF] = 8'hE9;

        reset_n   = 1'b0;
        run       = 1'b1;
        ready     = 1'b0;
        pc_load   = 1'b0;
        load_addr = 12'h000;

        // Reset held two cycles with run asserted.
        step();
        step();
        chk_all("reset", 1'b0, 4'h0, 4'h0, 12'h000);
        chk("reset.rom_addr", {4'd0, rom_addr}, 16'h0000);
        chk("reset.halted", {15'd0, halted}, 16'h0000);

        // Release: FETCH after one edge, valid after two.
        reset_n = 1'b1;
        step();
        chk("start.fetch_valid", {15'd0, valid}, 16'h0000);
        step();
        chk_all("start.first", 1'b1, 4'h1, 4'h2, 12'h001);

        // Streaming with ready high: one instruction every second cycle.
        ready = 1'b1;
        step();
        chk("stream1.gap", {15'd0, valid}, 16'h0000);
        step();
        chk_all("stream1", 1'b1, 4'h3, 4'h4, 12'h002);
        step();
        chk("stream2.gap", {15'd0, valid}, 16'h0000);
        step();
        chk_all("stream2", 1'b1, 4'h5, 4'h6, 12'h003);
        step();
        chk("stream3.gap", {15'd0, valid}, 16'h0000);
        step();
        chk_all("stream3", 1'b1, 4'h7, 4'h8, 12'h004);

        // Back-pressure: five cycles without ready, nothing moves.
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all("stall", 1'b1, 4'h7, 4'h8, 12'h004);
        end
        ready = 1'b1;
        step();
        chk("stall.accept", {15'd0, valid}, 16'h0000);
        ready = 1'b0;
        step();
        chk_all("stall.next", 1'b1, 4'h9, 4'hA, 12'h005);

        // Jump during FETCH: capture and increment cancelled.
        ready = 1'b1;
        step();
        chk("jump.in_fetch", {15'd0, valid}, 16'h0000);
        pc_load   = 1'b1;
        load_addr = 12'h0A5;
        step();
        pc_load   = 1'b0;
        chk_all("jump.load", 1'b0, 4'h9, 4'hA, 12'h0A5);
        step();
        chk_all("jump.fetch", 1'b0, 4'h9, 4'hA, 12'h0A5);
        step();
        chk_all("jump.target", 1'b1, 4'hC, 4'h3, 12'h0A6);

        // Jump during HOLD with ready high: handshake ignored, flushed to IDLE.
        pc_load   = 1'b1;
        load_addr = 12'hFFF;
        step();
        pc_load   = 1'b0;
        chk_all("flush.load", 1'b0, 4'hC, 4'h3, 12'hFFF);
        step();
        chk("flush.fetch", {15'd0, valid}, 16'h0000);
        step();
        chk_all("wrap.last", 1'b1, 4'hE, 4'h9, 12'h000);

`ifdef FETCH_HALT_ON_WRAP_EN
        step();
        chk("halt.enter", {15'd0, halted}, 16'h0001);
        chk("halt.valid", {15'd0, valid}, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("halt.stay", {14'd0, halted, valid}, 16'h0002);
        end
        pc_load   = 1'b1;
        load_addr = 12'h000;
        step();
        pc_load   = 1'b0;
        chk("halt.leave", {15'd0, halted}, 16'h0000);
        step();
        step();
        chk_all("halt.resume", 1'b1, 4'h1, 4'h2, 12'h001);
`else
        step();
        chk("wrap.gap", {15'd0, valid}, 16'h0000);
        chk("wrap.halted", {15'd0, halted}, 16'h0000);
        step();
        chk_all("wrap.next", 1'b1, 4'h1, 4'h2, 12'h001);
`endif

        // Reset while an instruction is pending.
        ready   = 1'b0;
        reset_n = 1'b0;
        step();
        chk_all("midreset", 1'b0, 4'h0, 4'h0, 12'h000);
        chk("midreset.halted", {15'd0, halted}, 16'h0000);
        reset_n = 1'b1;
        run     = 1'b0;
        step();
        chk("midreset.idle", {15'd0, valid}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
